alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one ALU32Bit instance between two requesters, e.g. the EX stage (port 0) and the branch-compare unit (port 1).
//  Arbitrates, latches the granted operation, drives the ALU for one evaluation cycle, then holds the result for the winner.
//  Requests use valid/ready handshakes; responses are valid/ready with a registered result.
// PARAMETERS
//  DATA_W  32  width of operands A/B and of the result
//  CTRL_W  4   width of the ALUControl op code (passed through, not decoded)
// PORTS
//  Clk         in   1       rising-edge clock
//  Rst         in   1       synchronous reset, active-low (0 = reset)
//  Req0Valid   in   1       requester 0 presents an operation
//  Req0Ready   out  1       requester 0 operation accepted this cycle
//  Req0Ctrl    in   CTRL_W  requester 0 op code
//  Req0A       in   DATA_W  requester 0 operand A
//  Req0B       in   DATA_W  requester 0 operand B
//  Req1Valid, Req1Ready, Req1Ctrl, Req1A, Req1B   same roles for requester 1
//  AluControl  out  CTRL_W  to ALU32Bit ALUControl
//  AluA        out  DATA_W  to ALU32Bit A
//  AluB        out  DATA_W  to ALU32Bit B
//  AluResult   in   DATA_W  from ALU32Bit ALUResult
//  AluZero     in   1       from ALU32Bit Zero
//  Rsp0Valid   out  1       result for requester 0 is available
//  Rsp0Ready   in   1       requester 0 consumes the result
//  Rsp0Result  out  DATA_W  captured ALU result
//  Rsp0Zero    out  1       captured Zero flag
//  Rsp1Valid, Rsp1Ready, Rsp1Result, Rsp1Zero   same roles for requester 1
// BEHAVIOUR
//  - Reset (Rst=0 at a Clk edge): state=IDLE; RR pointer=0; all outputs 0 (Ready, Valid, Alu*, Rsp*Result/Zero).
//  - FSM: IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE:
//    - ReqNReady is combinational: 1 only for the granted N while ReqNValid=1.
//    - Grant: if only one Valid, that one wins. If both, the RR pointer side wins.
//    - On transfer (Valid&Ready) latch Ctrl/A/B and the owner id, then go to EXEC.
//  - EXEC: AluControl/AluA/AluB show the latched op (they are driven from registers in all states).
//    - At the end of the cycle, capture AluResult/AluZero into the result regs; go to RESP.
//  - RESP: RspOwnerValid=1 with the captured Result/Zero, stable until RspOwnerReady=1.
//    - On Ready at an edge: Valid drops, RR pointer = other requester, return to IDLE.
//    - No new request is accepted in RESP.
//  - Latency: accepted at edge t, capture at t+1, RspValid high during cycle t+2 (2 cycles).
//    - Minimum 3 cycles per op, back to back.
//  - Other side's RspValid stays 0; both ReqReady are 0 outside IDLE.
//  - Requesters hold Ctrl/A/B stable while Valid=1 and Ready=0; the block does not sample before grant.
//  - Ctrl passes through unchecked (ALU codes 0,1,2,3,6,7,8,9,10,11).
//    - Undefined codes return whatever AluResult shows.
//  - Rst=0 mid-operation: the op is dropped, no response, pointer back to 0.
//  - RR pointer flips only when a response completes, even if only one side is requesting.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins a tie; RR pointer removed.
//  Not defined (default): round-robin as described above.
// TESTING
//  1 Reset: Rst=0 for 2 cycles, inputs random -> all outputs 0, Req*Ready=0.
//  2 Single op: Req0 Ctrl=2 A=5 B=7 -> Req0Ready same cycle; 2 cycles later Rsp0Valid=1, Result=12, Zero=0; Rsp1Valid=0.
//  3 Tie RR: both valid, Req0 SUB 9-9, Req1 OR 0xF0|0x0F, Rsp*Ready=1 -> Req0 first (Result=0, Zero=1).
//    - Then Req1 (Result=0xFF); a second tie grants Req1 first.
//  4 Backpressure: Rsp1Ready=0 for 5 cycles on SLT A=-1 B=1 -> Rsp1Valid held, Result=1 stable.
//    - Req0Valid during this window sees Req0Ready=0.
//  5 Reset mid-op: assert Rst=0 in EXEC -> no RspValid afterwards; next tie grants port 0.
//  6 Macro on: three consecutive ties -> port 0 granted all three.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU32Bit between two requesters.
// Each operation is granted in IDLE, the latched op drives the ALU during
// EXEC, and the captured result is held in RESP until the winner takes it.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0
// wins every tie, no round-robin pointer). Default build is round-robin.
//
// Handshake rule on every request and response channel: a transfer happens
// at a rising Clk edge where Valid=1 and Ready=1. A requester keeps Valid
// and its payload stable until that edge; the block keeps RspValid and the
// result stable until that edge.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [CTRL_W-1:0] Req0Ctrl,
  input  logic [DATA_W-1:0] Req0A,
  input  logic [DATA_W-1:0] Req0B,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [CTRL_W-1:0] Req1Ctrl,
  input  logic [DATA_W-1:0] Req1A,
  input  logic [DATA_W-1:0] Req1B,
  output logic [CTRL_W-1:0] AluControl,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  input  logic [DATA_W-1:0] AluResult,
  input  logic              AluZero,
  output logic              Rsp0Valid,
  input  logic              Rsp0Ready,
  output logic [DATA_W-1:0] Rsp0Result,
  output logic              Rsp0Zero,
  output logic              Rsp1Valid,
  input  logic              Rsp1Ready,
  output logic [DATA_W-1:0] Rsp1Result,
  output logic              Rsp1Zero,
  output logic [1:0]        DbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic              rsp_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Grant select: port 0 always wins when both request.
  always_comb begin
    gnt0 = Req0Valid;
    gnt1 = Req1Valid & ~Req0Valid;
  end
`else
  logic rr_ptr;

  // Grant select: a lone requester wins; a tie goes to the pointer side.
  always_comb begin
    gnt0 = Req0Valid & (~Req1Valid | ~rr_ptr);
    gnt1 = Req1Valid & (~Req0Valid | rr_ptr);
  end
`endif

  // Next-state and handshake outputs; Ready is masked while Rst is low so
  // nothing looks accepted during reset.
  always_comb begin
    state_nxt = state;
    Req0Ready = 1'b0;
    Req1Ready = 1'b0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    Rsp0Valid = 1'b0;
    Rsp1Valid = 1'b0;
    case (state)
      IDLE: begin
        Req0Ready = Rst & gnt0;
        Req1Ready = Rst & gnt1;
        accept    = Req0Ready | Req1Ready;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        Rsp0Valid = ~owner;
        Rsp1Valid = owner;
        rsp_done  = owner ? Rsp1Ready : Rsp0Ready;
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus operation/result latches; reset drops any op.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner  <= Req1Ready;
        ctrl_q <= Req1Ready ? Req1Ctrl : Req0Ctrl;
        a_q    <= Req1Ready ? Req1A : Req0A;
        b_q    <= Req1Ready ? Req1B : Req0B;
      end
      if (state == EXEC) begin
        res_q  <= AluResult;
        zero_q <= AluZero;
      end
`ifndef ALU_ARB_FIXED_PRIO_EN
      // Pointer moves to the other side only when a response completes.
      if (rsp_done) rr_ptr <= ~owner;
`endif
    end
  end

  assign AluControl = ctrl_q;
  assign AluA       = a_q;
  assign AluB       = b_q;
  assign Rsp0Result = res_q;
  assign Rsp0Zero   = zero_q;
  assign Rsp1Result = res_q;
  assign Rsp1Zero   = zero_q;
  assign DbgState   = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a small ALU model answers the shared ALU
// port, the main process issues directed operations, and a monitor pops
// hand-computed expected responses {port, zero, result} from exp_q.
module tb_alu_share_arbiter;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int EW     = DATA_W + 2;

  // ---------------- clock / reset / DUT ----------------
  logic              Clk = 1'b0;
  logic              Rst;
  logic              Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [CTRL_W-1:0] Req0Ctrl, Req1Ctrl, AluControl;
  logic [DATA_W-1:0] Req0A, Req0B, Req1A, Req1B, AluA, AluB, AluResult;
  logic              AluZero;
  logic              Rsp0Valid, Rsp0Ready, Rsp0Zero;
  logic              Rsp1Valid, Rsp1Ready, Rsp1Zero;
  logic [DATA_W-1:0] Rsp0Result, Rsp1Result;
  logic [1:0]        DbgState;

  always #5 Clk = ~Clk;

  alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Ctrl(Req0Ctrl),
    .Req0A(Req0A), .Req0B(Req0B),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Ctrl(Req1Ctrl),
    .Req1A(Req1A), .Req1B(Req1B),
    .AluControl(AluControl), .AluA(AluA), .AluB(AluB),
    .AluResult(AluResult), .AluZero(AluZero),
    .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready),
    .Rsp0Result(Rsp0Result), .Rsp0Zero(Rsp0Zero),
    .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready),
    .Rsp1Result(Rsp1Result), .Rsp1Zero(Rsp1Zero),
    .DbgState(DbgState)
  );

  // ALU32Bit stand-in: AND/OR/ADD/SUB/SLT, anything else a marker value.
  always_comb begin
    AluResult = 32'hDEAD_BEEF;
    case (AluControl)
      4'd0: AluResult = AluA & AluB;
      4'd1: AluResult = AluA | AluB;
      4'd2: AluResult = AluA + AluB;
      4'd6: AluResult = AluA - AluB;
      4'd7: AluResult = ($signed(AluA) < $signed(AluB)) ? 32'd1 : 32'd0;
      default: AluResult = 32'hDEAD_BEEF;
    endcase
    AluZero = (AluResult == 32'd0);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [EW-1:0] mk(input logic port, input logic zero,
                                       input logic [DATA_W-1:0] res);
    return {port, zero, res};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: one pop per completed response handshake.
  always @(negedge Clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    if (Rst && ((Rsp0Valid && Rsp0Ready) || (Rsp1Valid && Rsp1Ready))) begin
      act = {Rsp1Valid, Rsp1Valid ? Rsp1Zero : Rsp0Zero,
             Rsp1Valid ? Rsp1Result : Rsp0Result};
      n_cmp++;
      if (Rsp0Valid && Rsp1Valid) begin
        n_err++;
        $display("FAIL rsp_both_valid actual=11 required=one");
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected actual=%0h required=none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_err++;
          $display("FAIL rsp_data actual={port %0d zero %0d res %0h} required={port %0d zero %0d res %0h}",
                   act[EW-1], act[EW-2], act[DATA_W-1:0], exp[EW-1], exp[EW-2], exp[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int port, input logic [CTRL_W-1:0] ctrl,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bit got = 1'b0;
    if (port == 0) begin
      Req0Valid = 1'b1; Req0Ctrl = ctrl; Req0A = a; Req0B = b;
    end else begin
      Req1Valid = 1'b1; Req1Ctrl = ctrl; Req1A = a; Req1B = b;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk);
      got = (port == 0) ? Req0Ready : Req1Ready;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout port=%0d actual=0 required=1", port);
    end
    @(posedge Clk);
    #1;
    if (port == 0) Req0Valid = 1'b0;
    else Req1Valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge Clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge Clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // 1: reset with random inputs
    Rst       = 1'b0;
    Req0Valid = 1'($urandom_range(0, 1));
    Req1Valid = 1'($urandom_range(0, 1));
    Req0Ctrl  = 4'($urandom_range(0, 15));
    Req1Ctrl  = 4'($urandom_range(0, 15));
    Req0A     = $urandom; Req0B = $urandom;
    Req1A     = $urandom; Req1B = $urandom;
    Rsp0Ready = 1'($urandom_range(0, 1));
    Rsp1Ready = 1'($urandom_range(0, 1));
    repeat (2) @(negedge Clk);
    chk("rst_req0_ready", 64'(Req0Ready), 64'd0);
    chk("rst_req1_ready", 64'(Req1Ready), 64'd0);
    chk("rst_alu_ctrl", 64'(AluControl), 64'd0);
    chk("rst_alu_a", 64'(AluA), 64'd0);
    chk("rst_alu_b", 64'(AluB), 64'd0);
    chk("rst_rsp0_valid", 64'(Rsp0Valid), 64'd0);
    chk("rst_rsp1_valid", 64'(Rsp1Valid), 64'd0);
    chk("rst_rsp0_result", 64'(Rsp0Result), 64'd0);
    chk("rst_rsp1_result", 64'(Rsp1Result), 64'd0);
    chk("rst_rsp_zero", 64'({Rsp0Zero, Rsp1Zero}), 64'd0);
    chk("rst_state", 64'(DbgState), 64'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1; Req0Valid = 1'b0; Req1Valid = 1'b0;
    Rsp0Ready = 1'b1; Rsp1Ready = 1'b1;
    @(posedge Clk);
    #1;

    // 2: single op, ADD 5+7, with cycle-exact latency
    exp_q.push_back(mk(1'b0, 1'b0, 32'd12));
    issue(0, 4'd2, 32'd5, 32'd7);
    @(negedge Clk);
    chk("exec_rsp0_valid", 64'(Rsp0Valid), 64'd0);
    chk("exec_alu_op", 64'({AluControl, AluA, AluB}), {4'd2, 32'd5, 32'd7} );
    @(negedge Clk);
    chk("resp_rsp0_valid", 64'(Rsp0Valid), 64'd1);
    chk("resp_rsp1_valid", 64'(Rsp1Valid), 64'd0);
    chk("resp_rsp0_result", 64'(Rsp0Result), 64'd12);
    chk("resp_rsp0_zero", 64'(Rsp0Zero), 64'd0);
    wait_drain();
    // undefined op code passes straight through to the ALU
    exp_q.push_back(mk(1'b1, 1'b0, 32'hDEAD_BEEF));
    issue(1, 4'd9, 32'd1, 32'd2);
    wait_drain();

    // 3: tie with pointer at 0; port 0 re-requests so the second tie goes to port 1
    exp_q.push_back(mk(1'b0, 1'b1, 32'd0));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h0000_00FF));
    exp_q.push_back(mk(1'b0, 1'b0, 32'd7));
    fork
      begin
        issue(0, 4'd6, 32'd9, 32'd9);
        issue(0, 4'd2, 32'd3, 32'd4);
      end
      issue(1, 4'd1, 32'h0000_00F0, 32'h0000_000F);
    join
    wait_drain();

    // 4: backpressure on port 1 SLT -1 < 1 while port 0 waits
    Rsp1Ready = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 32'd1));
    exp_q.push_back(mk(1'b0, 1'b0, 32'd30));
    issue(1, 4'd7, 32'hFFFF_FFFF, 32'd1);
    fork
      issue(0, 4'd2, 32'd10, 32'd20);
    join_none
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_rsp1_valid", 64'(Rsp1Valid), 64'd1);
      chk("bp_rsp1_result", 64'(Rsp1Result), 64'd1);
      chk("bp_req0_ready", 64'(Req0Ready), 64'd0);
    end
    chk("bp_state", 64'(DbgState), 64'd2);
    @(posedge Clk);
    #1;
    Rsp1Ready = 1'b1;
    wait fork;
    wait_drain();

    // 5: reset during EXEC drops the op and clears the pointer
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0033));
    issue(0, 4'd1, 32'h0000_0030, 32'h0000_0003);
    wait_drain();
    issue(1, 4'd2, 32'd1, 32'd1);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("mid_rst_rsp_valid", 64'({Rsp0Valid, Rsp1Valid}), 64'd0);
    end
    chk("mid_rst_alu_a", 64'(AluA), 64'd0);
    @(posedge Clk);
    #1;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_000F));
    exp_q.push_back(mk(1'b1, 1'b0, 32'd7));
    fork
      issue(0, 4'd0, 32'h0000_00FF, 32'h0000_000F);
      issue(1, 4'd6, 32'd10, 32'd3);
    join
    wait_drain();

    // 6: three back-to-back requests on each side, all contending
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 1'b0, 32'(100 + i)));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 1'b0, 32'(200 + i)));
`else
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 32'(100 + i)));
      exp_q.push_back(mk(1'b1, 1'b0, 32'(200 + i)));
    end
`endif
    fork
      for (int i = 0; i < 3; i++) issue(0, 4'd2, 32'(i), 32'd100);
      for (int j = 0; j < 3; j++) issue(1, 4'd2, 32'(j), 32'd200);
    join
    wait_drain();

    // final report
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
